// File: rtl/mem_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_lsu_pkg
// Brief    : Shared constants, size encodings and FSM states for the LSU.
// Revision : 1.0 - initial release
// ============================================================================
package mem_lsu_pkg;

  localparam int MemTypeBusBits = 3;
  localparam int DataBusBits    = 64;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;

  localparam int ZEXT_BIT = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] lo);
    logic ok;
    case (size)
      SIZE_H:  ok = (lo[0] == 1'b0);
      SIZE_W:  ok = (lo[1:0] == 2'b00);
      SIZE_D:  ok = (lo == 3'b000);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lsu_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_lsu_if
// Brief    : Doubleword data-bus between the LSU (master) and memory (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface mem_lsu_if import mem_lsu_pkg::*; ();

  logic                   dReq_out;
  logic                   dWe_out;
  logic [DataBusBits-1:0] dAddr_out;
  logic [DataBusBits-1:0] dWdata_out;
  logic [7:0]             dStrb_out;
  logic                   dReady_in;
  logic                   dRvalid_in;
  logic [DataBusBits-1:0] dRdata_in;

  modport master (
    output dReq_out, dWe_out, dAddr_out, dWdata_out, dStrb_out,
    input  dReady_in, dRvalid_in, dRdata_in
  );

  modport slave (
    input  dReq_out, dWe_out, dAddr_out, dWdata_out, dStrb_out,
    output dReady_in, dRvalid_in, dRdata_in
  );

endinterface
`default_nettype wire

// File: rtl/mem_lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Brief    : Store lane placement, alignment check and load extract/extend.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_align import mem_lsu_pkg::*; (
  input  logic [MemTypeBusBits-1:0] i_req_type,
  input  logic [2:0]                i_req_lo,
  input  logic [DataBusBits-1:0]    i_wdata,
  output logic [7:0]                o_strb,
  output logic [DataBusBits-1:0]    o_wdata,
  output logic                      o_misalign,
  input  logic [MemTypeBusBits-1:0] i_ld_type,
  input  logic [2:0]                i_ld_lo,
  input  logic [DataBusBits-1:0]    i_rdata,
  output logic [DataBusBits-1:0]    o_ldata
);

  logic [7:0]             w_mask;
  logic [DataBusBits-1:0] w_shift;
  logic                   w_sext;

  always_comb begin
    case (i_req_type[1:0])
      SIZE_H:  w_mask = 8'h03;
      SIZE_W:  w_mask = 8'h0F;
      SIZE_D:  w_mask = 8'hFF;
      default: w_mask = 8'h01;
    endcase
    o_strb     = w_mask << i_req_lo;
    o_wdata    = i_wdata << {i_req_lo, 3'b000};
    o_misalign = !is_aligned(i_req_type[1:0], i_req_lo);
  end

  // The addressed bytes are brought to lane 0, then extended from the size's MSB.
  always_comb begin
    w_shift = i_rdata >> {i_ld_lo, 3'b000};
    w_sext  = !i_ld_type[ZEXT_BIT];
    case (i_ld_type[1:0])
      SIZE_B:  o_ldata = {{56{w_sext & w_shift[7]}},  w_shift[7:0]};
      SIZE_H:  o_ldata = {{48{w_sext & w_shift[15]}}, w_shift[15:0]};
      SIZE_W:  o_ldata = {{32{w_sext & w_shift[31]}}, w_shift[31:0]};
      default: o_ldata = w_shift;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : mem_lsu
// Brief    : Single-outstanding load/store unit with a four-state bus FSM.
// Revision : 1.0 - initial release
// ============================================================================
module mem_lsu import mem_lsu_pkg::*; (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      memRead_in,
  input  logic                      memWrite_in,
  input  logic [MemTypeBusBits-1:0] memType_in,
  input  logic [DataBusBits-1:0]    addr_in,
  input  logic [DataBusBits-1:0]    writeData_in,
  output logic                      stall_out,
  output logic [DataBusBits-1:0]    loadData_out,
  output logic                      loadValid_out,
  output logic                      misalign_out,
  mem_lsu_if.master                 dbus
);

  lsu_state_e r_state;
  lsu_state_e w_next;

  logic                      r_we;
  logic [DataBusBits-1:0]    r_addr;
  logic [DataBusBits-1:0]    r_wdata;
  logic [7:0]                r_strb;
  logic [MemTypeBusBits-1:0] r_ld_type;
  logic [2:0]                r_ld_lo;
  logic [DataBusBits-1:0]    r_ldata;
  logic                      r_lvalid;

  logic                      w_access;
  logic                      w_capture;
  logic                      w_misalign;
  logic [7:0]                w_st_strb;
  logic [DataBusBits-1:0]    w_st_wdata;
  logic [DataBusBits-1:0]    w_ld_data;

  lsu_align u_align (
    .i_req_type (memType_in),
    .i_req_lo   (addr_in[2:0]),
    .i_wdata    (writeData_in),
    .o_strb     (w_st_strb),
    .o_wdata    (w_st_wdata),
    .o_misalign (w_misalign),
    .i_ld_type  (r_ld_type),
    .i_ld_lo    (r_ld_lo),
    .i_rdata    (dbus.dRdata_in),
    .o_ldata    (w_ld_data)
  );

  assign w_access = memRead_in | memWrite_in;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    stall_out    = 1'b0;
    misalign_out = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_access) begin
          if (w_misalign) begin
            misalign_out = 1'b1;
          end else begin
            stall_out = 1'b1;
            w_capture = 1'b1;
            w_next    = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        stall_out = 1'b1;
        if (dbus.dReady_in) w_next = r_we ? ST_DONE : ST_WAIT;
      end
      ST_WAIT: begin
        stall_out = 1'b1;
        if (dbus.dRvalid_in) w_next = ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // A simultaneous read+write request is captured as a store.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_strb    <= 8'h00;
      r_ld_type <= '0;
      r_ld_lo   <= 3'b000;
      r_ldata   <= '0;
      r_lvalid  <= 1'b0;
    end else begin
      r_lvalid <= 1'b0;
      if (w_capture) begin
        r_we      <= memWrite_in;
        r_addr    <= {addr_in[DataBusBits-1:3], 3'b000};
        r_ld_type <= memType_in;
        r_ld_lo   <= addr_in[2:0];
        r_strb    <= memWrite_in ? w_st_strb : 8'hFF;
        r_wdata   <= memWrite_in ? w_st_wdata : '0;
      end
      if (r_state == ST_WAIT && dbus.dRvalid_in) begin
        r_ldata  <= w_ld_data;
        r_lvalid <= 1'b1;
      end
    end
  end

  assign dbus.dReq_out   = (r_state == ST_REQ);
  assign dbus.dWe_out    = r_we;
  assign dbus.dAddr_out  = r_addr;
  assign dbus.dWdata_out = r_wdata;
  assign dbus.dStrb_out  = r_strb;
  assign loadData_out    = r_ldata;
  assign loadValid_out   = r_lvalid;

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_lsu
// Brief    : Directed self-checking bench for mem_lsu.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        memRead_in, memWrite_in;
  logic [2:0]  memType_in;
  logic [63:0] addr_in, writeData_in;
  logic        stall_out, loadValid_out, misalign_out;
  logic [63:0] loadData_out;

  int n_vec  = 0;
  int n_miss = 0;

  mem_lsu_if dbus ();

  mem_lsu dut (
    .clk           (clk),
    .reset         (reset),
    .memRead_in    (memRead_in),
    .memWrite_in   (memWrite_in),
    .memType_in    (memType_in),
    .addr_in       (addr_in),
    .writeData_in  (writeData_in),
    .stall_out     (stall_out),
    .loadData_out  (loadData_out),
    .loadValid_out (loadValid_out),
    .misalign_out  (misalign_out),
    .dbus          (dbus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input string tag, input logic [2:0] t, input logic [63:0] a,
                          input logic [63:0] wd, input int waits, input logic rd_too,
                          input logic [7:0] exp_strb, input logic [63:0] exp_wd);
    memRead_in = rd_too; memWrite_in = 1'b1; memType_in = t; addr_in = a; writeData_in = wd;
    dbus.dReady_in = 1'b0;
    #1;
    chk({tag, " idle stall"}, 64'(stall_out), 64'd1);
    chk({tag, " idle noreq"}, 64'(dbus.dReq_out), 64'd0);
    tick();
    for (int i = 0; i <= waits; i++) begin
      dbus.dReady_in = (i == waits);
      #1;
      chk({tag, " req"},   64'(dbus.dReq_out), 64'd1);
      chk({tag, " we"},    64'(dbus.dWe_out), 64'd1);
      chk({tag, " addr"},  dbus.dAddr_out, a & ~64'h7);
      chk({tag, " strb"},  64'(dbus.dStrb_out), 64'(exp_strb));
      chk({tag, " wdata"}, dbus.dWdata_out, exp_wd);
      chk({tag, " stall"}, 64'(stall_out), 64'd1);
      tick();
    end
    memRead_in = 1'b0; memWrite_in = 1'b0; dbus.dReady_in = 1'b0;
    #1;
    chk({tag, " done stall"}, 64'(stall_out), 64'd0);
    chk({tag, " done lvalid"}, 64'(loadValid_out), 64'd0);
    chk({tag, " done noreq"}, 64'(dbus.dReq_out), 64'd0);
    tick();
  endtask

  task automatic do_load(input string tag, input logic [2:0] t, input logic [63:0] a,
                         input logic [63:0] rd, input logic [63:0] exp);
    memRead_in = 1'b1; memWrite_in = 1'b0; memType_in = t; addr_in = a;
    dbus.dReady_in = 1'b1;
    #1;
    chk({tag, " idle stall"}, 64'(stall_out), 64'd1);
    chk({tag, " idle misalign"}, 64'(misalign_out), 64'd0);
    tick();
    dbus.dRvalid_in = 1'b1; dbus.dRdata_in = ~rd;
    #1;
    chk({tag, " req"},   64'(dbus.dReq_out), 64'd1);
    chk({tag, " we"},    64'(dbus.dWe_out), 64'd0);
    chk({tag, " strb"},  64'(dbus.dStrb_out), 64'hFF);
    chk({tag, " addr"},  dbus.dAddr_out, a & ~64'h7);
    tick();
    dbus.dReady_in = 1'b0; dbus.dRvalid_in = 1'b1; dbus.dRdata_in = rd;
    #1;
    chk({tag, " wait stall"}, 64'(stall_out), 64'd1);
    chk({tag, " wait noreq"}, 64'(dbus.dReq_out), 64'd0);
    tick();
    dbus.dRvalid_in = 1'b0; memRead_in = 1'b0;
    #1;
    chk({tag, " done lvalid"}, 64'(loadValid_out), 64'd1);
    chk({tag, " done data"},   loadData_out, exp);
    chk({tag, " done stall"},  64'(stall_out), 64'd0);
    tick();
    #1;
    chk({tag, " after lvalid"}, 64'(loadValid_out), 64'd0);
    chk({tag, " hold data"},    loadData_out, exp);
  endtask

  initial begin
    reset = 1'b1; memRead_in = 1'b0; memWrite_in = 1'b0; memType_in = 3'b000;
    addr_in = '0; writeData_in = '0;
    dbus.dReady_in = 1'b0; dbus.dRvalid_in = 1'b0; dbus.dRdata_in = '0;
    tick(); tick();
    chk("rst dReq",   64'(dbus.dReq_out), 64'd0);
    chk("rst dWe",    64'(dbus.dWe_out), 64'd0);
    chk("rst dAddr",  dbus.dAddr_out, 64'd0);
    chk("rst dWdata", dbus.dWdata_out, 64'd0);
    chk("rst dStrb",  64'(dbus.dStrb_out), 64'd0);
    chk("rst ldata",  loadData_out, 64'd0);
    chk("rst lvalid", 64'(loadValid_out), 64'd0);
    reset = 1'b0;
    tick();
    chk("idle stall", 64'(stall_out), 64'd0);

    do_store("st_w",  3'b010, 64'h1004, 64'hDEADBEEF, 0, 1'b0, 8'hF0, 64'hDEADBEEF_00000000);
    do_store("st_b",  3'b000, 64'h1007, 64'hA5,       0, 1'b0, 8'h80, 64'hA5000000_00000000);
    do_store("st_h",  3'b001, 64'h100A, 64'hBEEF,     0, 1'b0, 8'h0C, 64'h00000000_BEEF0000);
    do_store("st_d5", 3'b011, 64'h7000, 64'h01234567_89ABCDEF, 5, 1'b0, 8'hFF, 64'h01234567_89ABCDEF);
    do_store("st_rw", 3'b011, 64'h4000, 64'h55AA55AA_12345678, 0, 1'b1, 8'hFF, 64'h55AA55AA_12345678);

    do_load("ld_bs", 3'b000, 64'h2003, 64'h00000000_80000000, 64'hFFFFFFFF_FFFFFF80);
    do_load("ld_wu", 3'b110, 64'h5004, 64'h89ABCDEF_01234567, 64'h00000000_89ABCDEF);
    do_load("ld_ws", 3'b010, 64'h5004, 64'h89ABCDEF_01234567, 64'hFFFFFFFF_89ABCDEF);
    do_load("ld_hs", 3'b001, 64'h6006, 64'h81234567_89ABCDEF, 64'hFFFFFFFF_FFFF8123);
    do_load("ld_d",  3'b011, 64'h7008, 64'h01234567_89ABCDEF, 64'h01234567_89ABCDEF);

    // Misaligned halfword load: flagged combinationally, never reaches the bus.
    memRead_in = 1'b1; memType_in = 3'b101; addr_in = 64'h3001; dbus.dReady_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mis flag",  64'(misalign_out), 64'd1);
      chk("mis stall", 64'(stall_out), 64'd0);
      chk("mis noreq", 64'(dbus.dReq_out), 64'd0);
      tick();
    end
    memRead_in = 1'b0; dbus.dReady_in = 1'b0;
    #1;
    chk("mis clear", 64'(misalign_out), 64'd0);
    chk("mis noreq2", 64'(dbus.dReq_out), 64'd0);

    // Reset while waiting for read data; the late response must be dropped.
    tick();
    memRead_in = 1'b1; memType_in = 3'b011; addr_in = 64'h8000; dbus.dReady_in = 1'b1;
    tick();
    tick();
    dbus.dReady_in = 1'b0;
    #1;
    chk("rw wait stall", 64'(stall_out), 64'd1);
    reset = 1'b1; dbus.dRvalid_in = 1'b1; dbus.dRdata_in = 64'h11112222_33334444;
    tick();
    memRead_in = 1'b0;
    #1;
    chk("rw noreq",  64'(dbus.dReq_out), 64'd0);
    chk("rw lvalid", 64'(loadValid_out), 64'd0);
    chk("rw ldata",  loadData_out, 64'd0);
    chk("rw stall",  64'(stall_out), 64'd0);
    reset = 1'b0;
    tick();
    #1;
    chk("rw late lvalid", 64'(loadValid_out), 64'd0);
    chk("rw late ldata",  loadData_out, 64'd0);
    chk("rw late noreq",  64'(dbus.dReq_out), 64'd0);
    dbus.dRvalid_in = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 The block SHALL have one clock and one reset: clk (input, 1) rising-edge clock; reset (input, 1), synchronous, active-high.
REQ-002 The block SHALL provide these pipeline-side ports, held stable by the EX/MEM register while stall_out=1:
- memRead_in  input  1  load request
- memWrite_in  input  1  store request
- memType_in  input  3  access type: [1:0] size (00 B, 01 H, 10 W, 11 D); [2]=1 zero-extend
- addr_in  input  64  byte address (ALU result)
- writeData_in  input  64  store data, right-aligned
REQ-003 The block SHALL provide these pipeline-side outputs:
- stall_out  output  1  freezes the pipeline
- loadData_out  output  64  extended load result
- loadValid_out  output  1  loadData_out is valid
- misalign_out  output  1  misaligned access flagged
REQ-004 The block SHALL provide these data-bus ports:
- dReq_out  output  1  request valid
- dWe_out  output  1  1 = write
- dAddr_out  output  64  doubleword address, bits [2:0] = 0
- dWdata_out  output  64  lane-aligned write data
- dStrb_out  output  8  byte strobes
- dReady_in  input  1  request accepted
- dRvalid_in  input  1  read data valid
- dRdata_in  input  64  read data

Function
REQ-005 FSM states SHALL be IDLE, REQ, WAIT and DONE.
REQ-006 IDLE: an aligned access (memRead_in or memWrite_in) SHALL assert stall_out combinationally, capture the request, and go to REQ.
REQ-007 REQ: dReq_out=1 with address, strobes and data from registers. If dReady_in=1: a write goes to DONE and a read goes to WAIT. Otherwise the state stays REQ and all bus outputs stay stable.
REQ-008 WAIT: dRvalid_in=1 SHALL register the extracted load data and go to DONE.
REQ-009 DONE: stall_out=0 for exactly one cycle, loadValid_out=1 for reads only, then return to IDLE regardless of inputs.
REQ-010 stall_out SHALL be 1 in REQ and WAIT, and in IDLE whenever an aligned access is presented.
REQ-011 Zero-wait-state latency SHALL be: load stalls 3 cycles (result in cycle 3); store stalls 2 cycles.
REQ-012 Alignment SHALL be: H needs addr[0]=0; W needs addr[1:0]=0; D needs addr[2:0]=0. B is always aligned.
REQ-013 A misaligned access SHALL make no bus request, set misalign_out=1 combinationally in IDLE and stall_out=0, and the FSM SHALL stay in IDLE.
REQ-014 Store lanes SHALL be: dStrb_out = size mask shifted left by addr[2:0]; dWdata_out = writeData_in shifted left by 8*addr[2:0]; dWe_out=1.
REQ-015 Loads SHALL use dStrb_out=0xFF and dWe_out=0. The result is dRdata_in shifted right by 8*addr[2:0], truncated to size, then sign- or zero-extended per memType_in[2].
REQ-016 memRead_in and memWrite_in both set SHALL execute as a store only.
REQ-017 dRvalid_in SHALL be ignored in IDLE, REQ and DONE.
REQ-018 loadData_out SHALL hold its last loaded value until the next load completes.

Reset
REQ-019 reset SHALL force state=IDLE, loadData_out=0, loadValid_out=0, dReq_out=0, dWe_out=0, dAddr_out=0, dWdata_out=0, dStrb_out=0.
REQ-020 Reset mid-operation (REQ or WAIT) SHALL drop dReq_out the next cycle. Any response that arrives later SHALL be discarded.
REQ-021 Reset SHALL take priority over every handshake input in the same cycle.

Structure
REQ-022 The shared constants header SHALL hold the size encodings, the zero-extend bit position, MemTypeBusBits=3, DataBusBits=64, and the FSM state encodings.
REQ-023 Store alignment and load extraction/extension SHALL live in one combinational sub-module, lsu_align. The FSM and registers SHALL live in mem_lsu.

Verification
REQ-024 Store W, addr=0x1004, data=0xDEADBEEF, dReady_in=1 -> dStrb_out=0xF0, dWdata_out=0xDEADBEEF_00000000, dAddr_out=0x1000, stall 2 cycles.
REQ-025 Load B signed, addr=0x2003, dRdata_in=0x00000000_80000000 with dRvalid_in one cycle after accept -> loadData_out=0xFFFFFFFF_FFFFFF80, loadValid_out high for 1 cycle.
REQ-026 Load H unsigned, addr=0x3001 -> misalign_out=1, dReq_out never asserts, stall_out=0.
REQ-027 Store D with dReady_in low for 5 cycles -> dReq_out, dAddr_out, dWdata_out and dStrb_out stable throughout, stall_out=1 until DONE.
REQ-028 reset asserted in WAIT, then dRvalid_in=1 -> state IDLE, loadValid_out stays 0, loadData_out=0.
REQ-029 memRead_in=memWrite_in=1, type D, addr=0x4000 -> single write with dStrb_out=0xFF and loadValid_out=0.
